// File: rtl/ysyx_25040129_mem_arbiter.sv
// Two-requester arbiter sharing one AXI4-Lite-style master port between IFU reads
// and LSU reads/writes; one transaction at a time, grant held until its response.
module ysyx_25040129_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // IFU AR/R
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    // LSU AR/R
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic [2:0]          lsu_arsize,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    // LSU AW/W/B
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    output logic [1:0]          lsu_bresp,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    // Downstream AR/R
    output logic [ADDR_W-1:0]   araddr,
    output logic [2:0]          arsize,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    // Downstream AW/W/B
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   last_ifu_q, last_ifu_d;

    logic ifu_req, lsu_r, lsu_w, lsu_any;
    state_t lsu_pick;

    assign ifu_req  = ifu_arvalid;
    assign lsu_r    = lsu_arvalid;
    assign lsu_w    = lsu_awvalid | lsu_wvalid;
    assign lsu_any  = lsu_r | lsu_w;
    assign lsu_pick = lsu_w ? LSU_WR : LSU_RD;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_ifu_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_ifu_q <= last_ifu_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_ifu_d = last_ifu_q;
        case (state_q)
            IDLE: begin
                // On a collision, the side that did not win last time goes first.
                if (ifu_req && lsu_any) begin
                    state_d = last_ifu_q ? lsu_pick : IFU_RD;
                end else if (lsu_any) begin
                    state_d = lsu_pick;
                end else if (ifu_req) begin
                    state_d = IFU_RD;
                end
                if (ifu_req || lsu_any) begin
                    last_ifu_d = (state_d == IFU_RD);
                end
            end
            IFU_RD:  if (rvalid && ifu_rready) state_d = IDLE;
            LSU_RD:  if (rvalid && lsu_rready) state_d = IDLE;
            LSU_WR:  if (bvalid && lsu_bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = 2'b00;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = 2'b00;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = 2'b00;
        lsu_bvalid  = 1'b0;
        araddr      = '0;
        arsize      = 3'b000;
        arvalid     = 1'b0;
        rready      = 1'b0;
        awaddr      = '0;
        awvalid     = 1'b0;
        wdata       = '0;
        wstrb       = '0;
        wvalid      = 1'b0;
        bready      = 1'b0;
        case (state_q)
            IFU_RD: begin
                araddr      = ifu_araddr;
                arsize      = 3'b010;
                arvalid     = ifu_arvalid;
                rready      = ifu_rready;
                ifu_arready = arready;
                ifu_rvalid  = rvalid;
                ifu_rresp   = rresp;
                ifu_rdata   = rdata;
                lsu_rdata   = rdata;
            end
            LSU_RD: begin
                araddr      = lsu_araddr;
                arsize      = lsu_arsize;
                arvalid     = lsu_arvalid;
                rready      = lsu_rready;
                lsu_arready = arready;
                lsu_rvalid  = rvalid;
                lsu_rresp   = rresp;
                ifu_rdata   = rdata;
                lsu_rdata   = rdata;
            end
            LSU_WR: begin
                // AW and W complete independently; only the B handshake ends the grant.
                awaddr      = lsu_awaddr;
                awvalid     = lsu_awvalid;
                wdata       = lsu_wdata;
                wstrb       = lsu_wstrb;
                wvalid      = lsu_wvalid;
                bready      = lsu_bready;
                lsu_awready = awready;
                lsu_wready  = wready;
                lsu_bvalid  = bvalid;
                lsu_bresp   = bresp;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ysyx_25040129_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter; inputs change 1 time unit after
// the rising edge and outputs are checked 1 time unit later.
module tb_ysyx_25040129_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid, ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid, ifu_rready;
    logic [31:0] lsu_araddr;
    logic [2:0]  lsu_arsize;
    logic        lsu_arvalid, lsu_arready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid, lsu_rready;
    logic [31:0] lsu_awaddr;
    logic        lsu_awvalid, lsu_awready;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_wvalid, lsu_wready;
    logic [1:0]  lsu_bresp;
    logic        lsu_bvalid, lsu_bready;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_25040129_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 0;
        lsu_araddr = '0; lsu_arsize = '0; lsu_arvalid = 0; lsu_rready = 0;
        lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 0;
        lsu_bready = 0;
        arready = 0; rdata = '0; rresp = '0; rvalid = 0;
        awready = 0; wready = 0; bresp = '0; bvalid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        tick();
        // Requests active while in reset must not leak to any output.
        ifu_arvalid = 1; ifu_araddr = 32'h1234_5678; lsu_awvalid = 1; lsu_wvalid = 1;
        lsu_awaddr = 32'hdead_beef; lsu_wdata = 32'hffff_ffff; lsu_wstrb = 4'hf;
        rdata = 32'hcafe_f00d; rvalid = 1; arready = 1; awready = 1; wready = 1; bvalid = 1;
        tick();
        settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin bad++;
            $display("FAIL reset_dn_valids got=%b exp=00000", {arvalid, awvalid, wvalid, rready, bready}); end
        total++; if ({ifu_arready, lsu_arready, lsu_awready, lsu_wready, ifu_rvalid, lsu_rvalid, lsu_bvalid} !== 7'b0) begin bad++;
            $display("FAIL reset_up_handshakes got=%b exp=0000000",
                     {ifu_arready, lsu_arready, lsu_awready, lsu_wready, ifu_rvalid, lsu_rvalid, lsu_bvalid}); end
        total++; if ({araddr, awaddr, wdata, wstrb, arsize, ifu_rdata, lsu_rdata} !== '0) begin bad++;
            $display("FAIL reset_payload got araddr=%h awaddr=%h wdata=%h wstrb=%h arsize=%h ifu_rdata=%h lsu_rdata=%h exp=all0",
                     araddr, awaddr, wdata, wstrb, arsize, ifu_rdata, lsu_rdata); end
        clear_inputs();
        tick();
        rst = 0;
    endtask

    task automatic test_ifu_fetch();
        clear_inputs();
        ifu_arvalid = 1; ifu_araddr = 32'h3000_0000;
        settle();
        total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL fetch_idle_arvalid got=%b exp=0", arvalid); end
        tick();
        arready = 1;
        settle();
        total++; if (arvalid !== 1'b1 || arsize !== 3'b010 || araddr !== 32'h3000_0000) begin bad++;
            $display("FAIL fetch_ar got arvalid=%b arsize=%b araddr=%h exp 1/010/30000000", arvalid, arsize, araddr); end
        total++; if (ifu_arready !== 1'b1 || lsu_arready !== 1'b0) begin bad++;
            $display("FAIL fetch_arready got ifu=%b lsu=%b exp 1/0", ifu_arready, lsu_arready); end
        tick();
        ifu_arvalid = 0; arready = 0;
        settle();
        total++; if (busy !== 1'b1 || arvalid !== 1'b0) begin bad++;
            $display("FAIL fetch_wait got busy=%b arvalid=%b exp 1/0", busy, arvalid); end
        tick();
        rvalid = 1; rdata = 32'h0000_0413; ifu_rready = 1;
        settle();
        total++; if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h0000_0413 || rready !== 1'b1 || lsu_rvalid !== 1'b0) begin bad++;
            $display("FAIL fetch_r got ifu_rvalid=%b ifu_rdata=%h rready=%b lsu_rvalid=%b exp 1/00000413/1/0",
                     ifu_rvalid, ifu_rdata, rready, lsu_rvalid); end
        tick();
        clear_inputs();
        settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL fetch_release got busy=%b exp=0", busy); end
    endtask

    // Completes the currently granted read: AR handshake, then one R beat.
    task automatic finish_read(input bit is_ifu, input logic [1:0] resp);
        arready = 1;
        tick();
        arready = 0;
        if (is_ifu) begin ifu_arvalid = 0; ifu_rready = 1; end
        else begin lsu_arvalid = 0; lsu_rready = 1; end
        rvalid = 1; rresp = resp; rdata = 32'h5555_aaaa;
        tick();
        rvalid = 0; rresp = 0; ifu_rready = 0; lsu_rready = 0;
    endtask

    task automatic test_round_robin();
        clear_inputs();
        do_reset();
        for (int round = 0; round < 2; round++) begin
            ifu_arvalid = 1; ifu_araddr = 32'h3000_0100;
            lsu_arvalid = 1; lsu_araddr = 32'h8000_0040; lsu_arsize = 3'b000;
            tick();
            settle();
            total++; if (araddr !== 32'h3000_0100 || arsize !== 3'b010 || arvalid !== 1'b1) begin bad++;
                $display("FAIL rr_first_ifu round=%0d got araddr=%h arsize=%b arvalid=%b exp 30000100/010/1",
                         round, araddr, arsize, arvalid); end
            finish_read(1'b1, 2'b00);
            settle();
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_gap round=%0d got busy=%b exp=0", round, busy); end
            tick();
            arready = 1;
            settle();
            total++; if (araddr !== 32'h8000_0040 || arsize !== 3'b000 || lsu_arready !== 1'b1 || ifu_arready !== 1'b0) begin bad++;
                $display("FAIL rr_second_lsu round=%0d got araddr=%h arsize=%b lsu_arready=%b ifu_arready=%b exp 80000040/000/1/0",
                         round, araddr, arsize, lsu_arready, ifu_arready); end
            arready = 0;
            finish_read(1'b0, 2'b00);
        end
    endtask

    task automatic test_write_priority();
        clear_inputs();
        do_reset();
        lsu_arvalid = 1; lsu_araddr = 32'h8000_0000; lsu_awvalid = 1; lsu_awaddr = 32'h8000_0010;
        tick();
        settle();
        total++; if (awvalid !== 1'b1 || arvalid !== 1'b0 || awaddr !== 32'h8000_0010) begin bad++;
            $display("FAIL wr_over_rd got awvalid=%b arvalid=%b awaddr=%h exp 1/0/80000010", awvalid, arvalid, awaddr); end
        clear_inputs();
        do_reset();
    endtask

    task automatic test_lsu_store();
        clear_inputs();
        arready = 1;
        lsu_awvalid = 1; lsu_awaddr = 32'h0f00_0004; lsu_wvalid = 1; lsu_wstrb = 4'b0010; lsu_wdata = 32'h0000_ab00;
        tick();
        awready = 1;
        settle();
        total++; if (awvalid !== 1'b1 || awaddr !== 32'h0f00_0004 || wvalid !== 1'b1 || wdata !== 32'h0000_ab00 || wstrb !== 4'b0010) begin bad++;
            $display("FAIL st_aw_w got awvalid=%b awaddr=%h wvalid=%b wdata=%h wstrb=%b exp 1/0f000004/1/0000ab00/0010",
                     awvalid, awaddr, wvalid, wdata, wstrb); end
        total++; if (lsu_awready !== 1'b1 || lsu_wready !== 1'b0 || ifu_arready !== 1'b0 || arvalid !== 1'b0) begin bad++;
            $display("FAIL st_readies got lsu_awready=%b lsu_wready=%b ifu_arready=%b arvalid=%b exp 1/0/0/0",
                     lsu_awready, lsu_wready, ifu_arready, arvalid); end
        tick();
        lsu_awvalid = 0; awready = 0;
        settle();
        total++; if (awvalid !== 1'b0 || wvalid !== 1'b1) begin bad++;
            $display("FAIL st_w_held got awvalid=%b wvalid=%b exp 0/1", awvalid, wvalid); end
        wready = 1;
        settle();
        total++; if (lsu_wready !== 1'b1) begin bad++; $display("FAIL st_wready got=%b exp=1", lsu_wready); end
        tick();
        lsu_wvalid = 0; wready = 0; bvalid = 1; bresp = 2'b00; lsu_bready = 1;
        settle();
        total++; if (lsu_bvalid !== 1'b1 || bready !== 1'b1 || lsu_bresp !== 2'b00 || ifu_arready !== 1'b0) begin bad++;
            $display("FAIL st_b got lsu_bvalid=%b bready=%b lsu_bresp=%b ifu_arready=%b exp 1/1/00/0",
                     lsu_bvalid, bready, lsu_bresp, ifu_arready); end
        tick();
        clear_inputs();
        settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL st_release got busy=%b exp=0", busy); end
    endtask

    task automatic test_error_resp();
        clear_inputs();
        lsu_arvalid = 1; lsu_araddr = 32'ha000_0000; lsu_arsize = 3'b001;
        tick();
        arready = 1;
        tick();
        arready = 0; lsu_arvalid = 0;
        rvalid = 1; rresp = 2'b10; rdata = 32'h0bad_0bad; lsu_rready = 1;
        settle();
        total++; if (lsu_rresp !== 2'b10 || lsu_rvalid !== 1'b1 || lsu_rdata !== 32'h0bad_0bad || ifu_rvalid !== 1'b0) begin bad++;
            $display("FAIL err_pass got lsu_rresp=%b lsu_rvalid=%b lsu_rdata=%h ifu_rvalid=%b exp 10/1/0bad0bad/0",
                     lsu_rresp, lsu_rvalid, lsu_rdata, ifu_rvalid); end
        tick();
        clear_inputs();
        settle();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL err_release got busy=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid_read();
        clear_inputs();
        lsu_arvalid = 1; lsu_araddr = 32'h8000_1000; lsu_arsize = 3'b010;
        tick();
        settle();
        total++; if (busy !== 1'b1 || arvalid !== 1'b1) begin bad++;
            $display("FAIL mid_pre got busy=%b arvalid=%b exp 1/1", busy, arvalid); end
        rst = 1;
        tick();
        rst = 0;
        settle();
        total++; if (busy !== 1'b0 || arvalid !== 1'b0 || lsu_arready !== 1'b0 || araddr !== 32'h0 || arsize !== 3'b000) begin bad++;
            $display("FAIL mid_reset got busy=%b arvalid=%b lsu_arready=%b araddr=%h arsize=%b exp 0/0/0/0/000",
                     busy, arvalid, lsu_arready, araddr, arsize); end
        clear_inputs();
        tick();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_ifu_fetch();
        test_round_robin();
        test_write_priority();
        test_lsu_store();
        test_error_resp();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_25040129_mem_arbiter.md
Name: ysyx_25040129_mem_arbiter

Overview:
- Shares one AXI4-Lite-style memory master port between two requesters: the IFU (read-only) and the LSU (read and write).
- Sits between the core front-end and the downstream xbar.
- Grants one transaction at a time and holds the grant until that transaction's response handshake completes.
- IFU and LSU reads are arbitrated round-robin; LSU writes compete in the same arbitration.

Parameters:
- ADDR_W, 32, address width of all AR/AW channels.
- DATA_W, 32, data width of R/W channels; wstrb width is DATA_W/8.

Ports (one line per channel; each signal listed with direction and width):
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- IFU AR: ifu_araddr in ADDR_W; ifu_arvalid in 1; ifu_arready out 1.
- IFU R: ifu_rdata out DATA_W; ifu_rresp out 2; ifu_rvalid out 1; ifu_rready in 1.
- LSU AR: lsu_araddr in ADDR_W; lsu_arsize in 3; lsu_arvalid in 1; lsu_arready out 1.
- LSU R: lsu_rdata out DATA_W; lsu_rresp out 2; lsu_rvalid out 1; lsu_rready in 1.
- LSU AW/W: lsu_awaddr in ADDR_W; lsu_awvalid in 1; lsu_awready out 1; lsu_wdata in DATA_W; lsu_wstrb in DATA_W/8; lsu_wvalid in 1; lsu_wready out 1.
- LSU B: lsu_bresp out 2; lsu_bvalid out 1; lsu_bready in 1.
- Downstream AR/R: araddr out ADDR_W; arsize out 3; arvalid out 1; arready in 1; rdata in DATA_W; rresp in 2; rvalid in 1; rready out 1.
- Downstream AW/W/B: awaddr out ADDR_W; awvalid out 1; awready in 1; wdata out DATA_W; wstrb out DATA_W/8; wvalid out 1; wready in 1; bresp in 2; bvalid in 1; bready out 1.
- busy  out  1  high whenever a grant is held (state != IDLE).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- State register has four states: IDLE, IFU_RD, LSU_RD, LSU_WR.
- Reset:
  - state <= IDLE; last_ifu <= 0.
  - All outputs are combinational from state, so at reset every valid, ready, addr, data, strb and size output is 0 and busy=0.
- IDLE:
  - Drives nothing downstream; all master-side readies and valids are 0.
  - Request terms: ifu_req = ifu_arvalid; lsu_r = lsu_arvalid; lsu_w = lsu_awvalid | lsu_wvalid.
- Grant decision in IDLE, registered, effective the next cycle:
  - lsu_w and lsu_r both high: LSU_WR (write beats LSU read).
  - LSU request alone: LSU_WR or LSU_RD.
  - ifu_req alone: IFU_RD.
  - IFU and an LSU request together: LSU wins if last_ifu=1, IFU wins if last_ifu=0.
  - last_ifu is updated on every grant: 1 if IFU granted, else 0.
- Arbitration latency: exactly one cycle from valid-in-IDLE to the downstream valid. Masters hold valid and payload stable until their ready; the arbiter does not latch any payload.
- IFU_RD:
  - Downstream: araddr=ifu_araddr, arsize=3'b010, arvalid=ifu_arvalid, rready=ifu_rready.
  - IFU side: ifu_arready=arready, ifu_rvalid=rvalid, ifu_rresp=rresp.
  - Exit to IDLE on the cycle rvalid&&rready.
- LSU_RD:
  - Same as IFU_RD but routed to lsu_*; arsize=lsu_arsize.
  - Exit to IDLE on rvalid&&rready.
- LSU_WR:
  - awaddr, awvalid, wdata, wstrb and wvalid are driven from lsu_*; lsu_awready=awready, lsu_wready=wready.
  - AW and W may complete in either order or in the same cycle; the arbiter does not track them.
  - lsu_bvalid=bvalid, lsu_bresp=bresp, bready=lsu_bready.
  - Exit to IDLE on bvalid&&bready.
- Gating:
  - rdata is fanned out to both ifu_rdata and lsu_rdata.
  - Every non-owner valid and ready is forced to 0; downstream channels unused by the owner are driven 0.
- Responses: rresp and bresp values are passed through unchanged, including error codes. The grant is released on the response handshake regardless of resp.
- Back-to-back: after exit the state is IDLE for one cycle, so the minimum gap between downstream transactions is one IDLE cycle.
- Reset mid-transaction: state returns to IDLE and the outstanding transaction is abandoned. The downstream slave shares rst and is reset in the same cycle.

Test Plan:
- IFU fetch alone:
  - Stimulus: ifu_arvalid=1, ifu_araddr=0x3000_0000; slave arready=1 at cycle 1, rvalid=1 with rdata=0x0000_0413 at cycle 3.
  - Required: arvalid=1 and arsize=3'b010 at cycle 1; ifu_rvalid=1 with ifu_rdata=0x0000_0413 at cycle 3; IDLE and busy=0 at cycle 4.
- Simultaneous IFU and LSU read after reset (last_ifu=0):
  - Required: IFU granted first, then LSU.
  - Repeating the collision with the same request pattern must alternate the grant (round-robin).
- LSU store:
  - Stimulus: awaddr=0x0f00_0004, wstrb=4'b0010, wdata=0x0000_ab00; awready one cycle before wready.
  - Required: downstream holds wvalid until wready; lsu_bvalid follows bvalid; ifu_arready stays 0 throughout.
- Error response:
  - Stimulus: rresp=2'b10 on an LSU read.
  - Required: lsu_rresp=2'b10 passed through; grant released on that rvalid&&rready.
- Reset mid-read:
  - Stimulus: assert rst while in LSU_RD with arready still low.
  - Required: next cycle state=IDLE, all outputs 0, busy=0.
